// File: rtl/hss_tx_framer.sv
// HSS link transmit word framer on the CLKDIV (txdivclk) domain: training burst, then valid/ready user stream.
// Define HSS_TX_PRBS_EN to source training words from a PRBS-7 generator instead of the incrementing counter.
module hss_tx_framer #(
  parameter int         N           = 3,
  parameter int         TRAIN_WORDS = 256,
  parameter logic [7:0] SYNC_WORD   = 8'h01,
  parameter logic [7:0] CLK_WORD    = 8'hAA,
  parameter logic [7:0] IDLE_WORD   = 8'h00
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [N*8-1:0] s_data,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic           train_req,
  output logic           training,
  output logic [7:0]     clk_word,
  output logic [7:0]     sync_word,
  output logic [N*8-1:0] lane_data
);

  localparam int W  = N * 8;
  localparam int IW = (TRAIN_WORDS > 2) ? $clog2(TRAIN_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(TRAIN_WORDS - 1);

  localparam logic [0:0] ST_TRAIN = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] word_idx;
  logic [W-1:0]  train_word;
  logic          last_word;
  logic          pat_load;
  logic          xfer;

  assign last_word = (state == ST_TRAIN) && (word_idx == LAST_IDX);
  // The pattern source sits at its start value whenever the next burst could begin.
  assign pat_load  = (state == ST_RUN) || last_word;
  assign s_ready   = (state == ST_RUN) && !train_req && resetn;
  assign xfer      = s_valid && s_ready;

`ifdef HSS_TX_PRBS_EN
  logic [6:0] prbs;
  logic [7:0] prbs_byte;
  logic [6:0] prbs_next;

  // x^7+x^6+1, eight steps per clock; bit0 of the byte is the first bit serialised.
  always_comb begin
    prbs_next = prbs;
    prbs_byte = '0;
    for (int b = 0; b < 8; b++) begin
      prbs_byte[b] = prbs_next[6] ^ prbs_next[5];
      prbs_next    = {prbs_next[5:0], prbs_byte[b]};
    end
  end

  assign train_word = {N{prbs_byte}};

  always_ff @(posedge clk) begin
    if (!resetn || pat_load) begin
      prbs <= 7'h7F;
    end else begin
      prbs <= prbs_next;
    end
  end
`else
  logic [W-1:0] cnt;

  assign train_word = cnt;

  always_ff @(posedge clk) begin
    if (!resetn || pat_load) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_TRAIN;
      word_idx  <= '0;
      training  <= 1'b0;
      lane_data <= '0;
      clk_word  <= 8'h00;
      sync_word <= 8'h00;
    end else begin
      clk_word  <= CLK_WORD;
      sync_word <= SYNC_WORD;
      if (state == ST_TRAIN) begin
        training  <= 1'b1;
        lane_data <= train_word;
        if (last_word) begin
          word_idx <= '0;
          state    <= train_req ? ST_TRAIN : ST_RUN;
        end else begin
          word_idx <= word_idx + 1'b1;
        end
      end else begin
        training  <= 1'b0;
        lane_data <= xfer ? s_data : {N{IDLE_WORD}};
        word_idx  <= '0;
        if (train_req) begin
          state <= ST_TRAIN;
        end
      end
    end
  end

endmodule
